// File: rtl/serial_sub_ctrl_pkg.sv
// Shared types and constants for the bit-serial subtract controller.
// The FSM encoding and default width live here so the interface, top and bench agree.
package serial_sub_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bit counter must be able to hold the value WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Request/result bundle between a requesting datapath and serial_sub_ctrl.
// The zero flag exists only when SERIAL_SUB_ZERO_EN is defined.
interface serial_sub_ctrl_if
    import serial_sub_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_ZERO_EN
    logic             zero;
`endif

    modport master (
        output start, a, b, bin,
`ifdef SERIAL_SUB_ZERO_EN
        input  zero,
`endif
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
`ifdef SERIAL_SUB_ZERO_EN
        output zero,
`endif
        output busy, done, diff, bout
    );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
// Purely combinational; all sequencing lives in the controller.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B - Bin over WIDTH cycles through a single full_subtractor, LSB first.
// Optional zero-result flag enabled by defining SERIAL_SUB_ZERO_EN.
module serial_sub_ctrl
    import serial_sub_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    serial_sub_ctrl_if.slave bus
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_ZERO_EN
    logic             zero_q, zero_d;
`endif

    logic fs_d;
    logic fs_bout;

    full_subtractor u_fs (
        .a    (sh_a_q[0]),
        .b    (sh_b_q[0]),
        .bin  (brw_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_ZERO_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_ZERO_EN
            zero_q  <= zero_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_ZERO_EN
        zero_d  = zero_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sh_a_d  = bus.a;
                    sh_b_d  = bus.b;
                    brw_d   = bus.bin;
                    cnt_d   = '0;
                    diff_d  = '0;
                    bout_d  = 1'b0;
`ifdef SERIAL_SUB_ZERO_EN
                    zero_d  = 1'b1;
`endif
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                // Difference bits enter at the MSB so bit 0 lands at diff[0] after WIDTH shifts.
                sh_a_d = {1'b0, sh_a_q[WIDTH-1:1]};
                sh_b_d = {1'b0, sh_b_q[WIDTH-1:1]};
                diff_d = {fs_d, diff_q[WIDTH-1:1]};
                brw_d  = fs_bout;
                cnt_d  = cnt_q + CNT_W'(1);
`ifdef SERIAL_SUB_ZERO_EN
                if (fs_d) begin
                    zero_d = 1'b0;
                end
`endif
                if (cnt_q == LAST_BIT) begin
                    bout_d  = fs_bout;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q == S_RUN) || (state_q == S_DONE);
    assign bus.done = (state_q == S_DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUB_ZERO_EN
    assign bus.zero = zero_q;
`endif

endmodule
